// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared encodings and types for the RAM bus arbiter
package ram_arb_pkg;

  // Master identifiers, also used as the round-robin pointer and the in-flight tag
  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_M1  = 1'b1;

  // Width of the M1 lock run counter (LOCK_MAX is limited to 255)
  localparam int LOCK_CNT_W = 8;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_type_e;

  // One captured CPU access waiting for a slave slot
  typedef struct packed {
    req_type_e   typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } cpu_req_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-requester round-robin picker with M1 lock override
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,      // bit 0 = CPU, bit 1 = M1
  input  logic       last,     // master granted most recently
  input  logic       lock_ok,  // M1 may keep the slot on contention
  output logic [1:0] grant     // one-hot, same bit order as req
);

  // A lone requester always wins; on contention the master not served last wins unless M1 holds the lock
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (lock_ok || (last == MASTER_CPU)) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// rtl/ram_bus_arbiter.sv - shares the single RAM port between the CPU and the framebuffer fetch engine
module ram_bus_arbiter
  import ram_arb_pkg::*;
#(
  parameter int LOCK_MAX  = 8,
  parameter bit CPU_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wmask,
  input  logic        cpu_rstrb,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rbusy,
  output logic        cpu_wbusy,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_rstrb,
  input  logic [31:0] s_rdata
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_LIMIT = LOCK_CNT_W'(LOCK_MAX);

  logic                  pend_valid;
  cpu_req_t              pend;
  logic                  rr_last;
  logic                  lock_armed;
  logic [LOCK_CNT_W-1:0] lock_cnt;
  logic                  infl_valid;
  logic                  infl_tag;
  logic                  cpu_strobe;
  logic                  lock_ok;
  logic [1:0]            grant;
  logic                  gnt_cpu;
  logic                  gnt_m1;

  assign cpu_strobe = cpu_rstrb | (|cpu_wmask);

  // lock_armed stays low until M1 has really been served, so the reset value of rr_last cannot start a lock run
  assign lock_ok = lock_armed && m1_lock && (lock_cnt < LOCK_LIMIT);

  rr_pick2 u_pick (
    .req     ({m1_req, pend_valid}),
    .last    (rr_last),
    .lock_ok (lock_ok),
    .grant   (grant)
  );

  assign gnt_cpu = grant[0];
  assign gnt_m1  = grant[1];

  // Capture one CPU strobe into the pending slot; a write wins over a simultaneous read
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_valid <= 1'b0;
      pend       <= '0;
    end else begin
      if (gnt_cpu) begin
        pend_valid <= 1'b0;
      end
      if (cpu_strobe && !pend_valid) begin
        pend_valid <= 1'b1;
        pend.typ   <= (|cpu_wmask) ? REQ_WR : REQ_RD;
        pend.addr  <= cpu_addr;
        pend.wdata <= cpu_wdata;
        pend.wmask <= cpu_wmask;
      end
    end
  end

  // Round-robin pointer and M1 lock run length; the pointer holds the last granted master
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_last    <= CPU_FIRST;
      lock_armed <= 1'b0;
      lock_cnt   <= '0;
    end else begin
      if (gnt_cpu) begin
        rr_last    <= MASTER_CPU;
        lock_armed <= 1'b0;
      end else if (gnt_m1) begin
        rr_last    <= MASTER_M1;
        lock_armed <= 1'b1;
      end
      if (gnt_cpu || !m1_lock) begin
        lock_cnt <= '0;
      end else if (gnt_m1 && (lock_cnt < LOCK_LIMIT)) begin
        lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

  // Remember who owns the read issued this cycle so next cycle's s_rdata goes to the right master
  always_ff @(posedge clk) begin
    if (!resetn) begin
      infl_valid <= 1'b0;
      infl_tag   <= MASTER_CPU;
    end else begin
      infl_valid <= s_rstrb;
      infl_tag   <= gnt_m1 ? MASTER_M1 : MASTER_CPU;
    end
  end

  // Drive the slave port from the winner; when idle only the strobes drop, address/data keep the pending values
  always_comb begin
    s_addr  = pend.addr;
    s_wdata = pend.wdata;
    s_wmask = 4'b0000;
    s_rstrb = 1'b0;
    if (gnt_m1) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wmask = m1_we ? m1_wmask : 4'b0000;
      s_rstrb = !m1_we;
    end else if (gnt_cpu) begin
      s_wmask = (pend.typ == REQ_WR) ? pend.wmask : 4'b0000;
      s_rstrb = (pend.typ == REQ_RD);
    end
  end

  // Busy flags, grant pulse and read-data routing back to each master
  always_comb begin
    cpu_rbusy = pend_valid && (pend.typ == REQ_RD);
    cpu_wbusy = pend_valid && (pend.typ == REQ_WR);
    m1_gnt    = gnt_m1;
    m1_rvalid = infl_valid && (infl_tag == MASTER_M1);
    m1_rdata  = m1_rvalid ? s_rdata : 32'h0;
    cpu_rdata = (infl_valid && (infl_tag == MASTER_CPU)) ? s_rdata : 32'h0;
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb/tb_ram_bus_arbiter.sv - directed self-checking bench for ram_bus_arbiter
module tb_ram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wmask;
  logic        cpu_rstrb;
  logic [31:0] cpu_rdata;
  logic        cpu_rbusy;
  logic        cpu_wbusy;
  logic        m1_req;
  logic        m1_we;
  logic        m1_lock;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wmask;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wmask;
  logic        s_rstrb;
  logic [31:0] s_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:255];

  always #5 clk = ~clk;

  ram_bus_arbiter #(.LOCK_MAX(4), .CPU_FIRST(1'b1)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wmask (cpu_wmask),
    .cpu_rstrb (cpu_rstrb),
    .cpu_rdata (cpu_rdata),
    .cpu_rbusy (cpu_rbusy),
    .cpu_wbusy (cpu_wbusy),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_lock   (m1_lock),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wmask  (m1_wmask),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wmask   (s_wmask),
    .s_rstrb   (s_rstrb),
    .s_rdata   (s_rdata)
  );

  // Memory: registered read, byte-masked write
  always @(posedge clk) begin
    if (s_rstrb) s_rdata <= ram[s_addr[9:2]];
    for (int b = 0; b < 4; b++) begin
      if (s_wmask[b]) ram[s_addr[9:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    next_cycle();
    next_cycle();
    sample();
    checks++; if (cpu_rbusy !== 1'b0) begin errors++; $display("FAIL reset_rbusy: got %b want 0", cpu_rbusy); end
    checks++; if (cpu_wbusy !== 1'b0) begin errors++; $display("FAIL reset_wbusy: got %b want 0", cpu_wbusy); end
    checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", m1_gnt); end
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", m1_rvalid); end
    checks++; if (s_rstrb !== 1'b0) begin errors++; $display("FAIL reset_rstrb: got %b want 0", s_rstrb); end
    checks++; if (s_wmask !== 4'b0000) begin errors++; $display("FAIL reset_wmask: got %b want 0000", s_wmask); end
    next_cycle();
    resetn = 1'b1;
  endtask

  task automatic test_cpu_read();
    next_cycle();
    cpu_addr = 32'h0000_0010; cpu_rstrb = 1'b1;
    sample();
    checks++; if (s_rstrb !== 1'b0) begin errors++; $display("FAIL rd_t0_rstrb: got %b want 0", s_rstrb); end
    next_cycle();
    cpu_rstrb = 1'b0;
    sample();
    checks++; if (s_rstrb !== 1'b1) begin errors++; $display("FAIL rd_t1_rstrb: got %b want 1", s_rstrb); end
    checks++; if (s_addr !== 32'h0000_0010) begin errors++; $display("FAIL rd_t1_addr: got %h want 00000010", s_addr); end
    checks++; if (cpu_rbusy !== 1'b1) begin errors++; $display("FAIL rd_t1_rbusy: got %b want 1", cpu_rbusy); end
    next_cycle();
    sample();
    checks++; if (cpu_rbusy !== 1'b0) begin errors++; $display("FAIL rd_t2_rbusy: got %b want 0", cpu_rbusy); end
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_t2_data: got %h want deadbeef", cpu_rdata); end
  endtask

  task automatic test_cpu_write();
    next_cycle();
    cpu_addr = 32'h0000_0020; cpu_wdata = 32'h1234_ABCD; cpu_wmask = 4'b0011;
    sample();
    checks++; if (cpu_wbusy !== 1'b0) begin errors++; $display("FAIL wr_t0_wbusy: got %b want 0", cpu_wbusy); end
    next_cycle();
    cpu_wmask = 4'b0000;
    sample();
    checks++; if (s_wmask !== 4'b0011) begin errors++; $display("FAIL wr_t1_wmask: got %b want 0011", s_wmask); end
    checks++; if (s_wdata !== 32'h1234_ABCD) begin errors++; $display("FAIL wr_t1_wdata: got %h want 1234abcd", s_wdata); end
    checks++; if (cpu_wbusy !== 1'b1) begin errors++; $display("FAIL wr_t1_wbusy: got %b want 1", cpu_wbusy); end
    checks++; if (s_rstrb !== 1'b0) begin errors++; $display("FAIL wr_t1_rstrb: got %b want 0", s_rstrb); end
    next_cycle();
    sample();
    checks++; if (cpu_wbusy !== 1'b0) begin errors++; $display("FAIL wr_t2_wbusy: got %b want 0", cpu_wbusy); end
    checks++; if (s_wmask !== 4'b0000) begin errors++; $display("FAIL wr_t2_wmask: got %b want 0000", s_wmask); end
    next_cycle();
    cpu_rstrb = 1'b1;
    next_cycle();
    cpu_rstrb = 1'b0;
    next_cycle();
    sample();
    checks++; if (cpu_rdata !== 32'hA500_ABCD) begin errors++; $display("FAIL wr_readback: got %h want a500abcd", cpu_rdata); end
  endtask

  task automatic test_contention();
    next_cycle();
    cpu_addr = 32'h0000_0030; cpu_rstrb = 1'b1;
    next_cycle();
    cpu_rstrb = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0040;
    sample();
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL cont_t1_gnt: got %b want 1", m1_gnt); end
    checks++; if (s_addr !== 32'h0000_0040) begin errors++; $display("FAIL cont_t1_addr: got %h want 00000040", s_addr); end
    checks++; if (cpu_rbusy !== 1'b1) begin errors++; $display("FAIL cont_t1_rbusy: got %b want 1", cpu_rbusy); end
    next_cycle();
    m1_req = 1'b0;
    sample();
    checks++; if (m1_rvalid !== 1'b1) begin errors++; $display("FAIL cont_t2_rvalid: got %b want 1", m1_rvalid); end
    checks++; if (m1_rdata !== 32'hA500_0010) begin errors++; $display("FAIL cont_t2_m1data: got %h want a5000010", m1_rdata); end
    checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL cont_t2_gnt: got %b want 0", m1_gnt); end
    checks++; if ((s_rstrb !== 1'b1) || (s_addr !== 32'h0000_0030)) begin errors++; $display("FAIL cont_t2_cpu_issue: got rstrb %b addr %h want 1 00000030", s_rstrb, s_addr); end
    checks++; if (cpu_rbusy !== 1'b1) begin errors++; $display("FAIL cont_t2_rbusy: got %b want 1", cpu_rbusy); end
    next_cycle();
    sample();
    checks++; if (cpu_rbusy !== 1'b0) begin errors++; $display("FAIL cont_t3_rbusy: got %b want 0", cpu_rbusy); end
    checks++; if (cpu_rdata !== 32'hA500_000C) begin errors++; $display("FAIL cont_t3_cpudata: got %h want a500000c", cpu_rdata); end
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL cont_t3_rvalid: got %b want 0", m1_rvalid); end
  endtask

  task automatic test_lock();
    logic [5:0] gnt_exp;
    gnt_exp = 6'b101111;
    next_cycle();
    cpu_addr = 32'h0000_0010; cpu_rstrb = 1'b1;
    m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0040;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        next_cycle();
        cpu_rstrb = 1'b0;
      end
      sample();
      checks++; if (m1_gnt !== gnt_exp[k]) begin errors++; $display("FAIL lock_gnt_slot%0d: got %b want %b", k, m1_gnt, gnt_exp[k]); end
      if (k == 4) begin
        checks++; if ((s_rstrb !== 1'b1) || (s_addr !== 32'h0000_0010)) begin errors++; $display("FAIL lock_cpu_issue: got rstrb %b addr %h want 1 00000010", s_rstrb, s_addr); end
        checks++; if (cpu_rbusy !== 1'b1) begin errors++; $display("FAIL lock_slot4_rbusy: got %b want 1", cpu_rbusy); end
      end
      if (k == 5) begin
        checks++; if (cpu_rbusy !== 1'b0) begin errors++; $display("FAIL lock_slot5_rbusy: got %b want 0", cpu_rbusy); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lock_cpudata: got %h want deadbeef", cpu_rdata); end
      end
    end
    next_cycle();
    m1_req = 1'b0; m1_lock = 1'b0;
    sample();
    checks++; if ((m1_rvalid !== 1'b1) || (m1_rdata !== 32'hA500_0010)) begin errors++; $display("FAIL lock_m1_tail: got rvalid %b data %h want 1 a5000010", m1_rvalid, m1_rdata); end
  endtask

  task automatic test_reset_inflight();
    next_cycle();
    cpu_addr = 32'h0000_0010; cpu_rstrb = 1'b1;
    next_cycle();
    cpu_rstrb = 1'b0; resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    sample();
    checks++; if (cpu_rbusy !== 1'b0) begin errors++; $display("FAIL rst_cpu_rbusy: got %b want 0", cpu_rbusy); end
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_cpu_rvalid: got %b want 0", m1_rvalid); end
    next_cycle();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0040; resetn = 1'b0;
    next_cycle();
    m1_req = 1'b0; resetn = 1'b1;
    sample();
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_m1_drop: got %b want 0", m1_rvalid); end
    next_cycle();
    cpu_addr = 32'h0000_0010; cpu_rstrb = 1'b1;
    next_cycle();
    cpu_rstrb = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h0000_0040;
    sample();
    checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL rst_first_gnt: got %b want 0", m1_gnt); end
    checks++; if ((s_rstrb !== 1'b1) || (s_addr !== 32'h0000_0010)) begin errors++; $display("FAIL rst_first_issue: got rstrb %b addr %h want 1 00000010", s_rstrb, s_addr); end
    next_cycle();
    sample();
    checks++; if ((cpu_rbusy !== 1'b0) || (cpu_rdata !== 32'hDEAD_BEEF)) begin errors++; $display("FAIL rst_first_data: got rbusy %b data %h want 0 deadbeef", cpu_rbusy, cpu_rdata); end
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL rst_m1_after: got %b want 1", m1_gnt); end
    next_cycle();
    m1_req = 1'b0;
    sample();
    checks++; if ((m1_rvalid !== 1'b1) || (m1_rdata !== 32'hA500_0010)) begin errors++; $display("FAIL rst_m1_data: got rvalid %b data %h want 1 a5000010", m1_rvalid, m1_rdata); end
  endtask

  task automatic test_back_to_back();
    logic        exp_gnt;
    logic        exp_odd;
    logic [31:0] exp_data;
    for (int k = 0; k < 18; k++) begin
      next_cycle();
      cpu_rstrb = ((k % 2) == 0) && (k <= 14);
      cpu_addr  = 32'h0000_0200 + 32'(4 * (k / 2));
      m1_req    = (k <= 14);
      m1_we     = 1'b0;
      m1_addr   = 32'h0000_0100 + 32'(4 * ((k + 1) / 2));
      sample();
      exp_gnt = ((k % 2) == 0) && (k <= 14);
      exp_odd = ((k % 2) == 1) && (k <= 15);
      checks++; if (m1_gnt !== exp_gnt) begin errors++; $display("FAIL b2b_gnt_c%0d: got %b want %b", k, m1_gnt, exp_gnt); end
      checks++; if (cpu_rbusy !== exp_odd) begin errors++; $display("FAIL b2b_rbusy_c%0d: got %b want %b", k, cpu_rbusy, exp_odd); end
      checks++; if (m1_rvalid !== exp_odd) begin errors++; $display("FAIL b2b_rvalid_c%0d: got %b want %b", k, m1_rvalid, exp_odd); end
      if (exp_odd) begin
        exp_data = 32'hA500_0040 + 32'((k - 1) / 2);
        checks++; if (m1_rdata !== exp_data) begin errors++; $display("FAIL b2b_m1data_c%0d: got %h want %h", k, m1_rdata, exp_data); end
      end
      if (((k % 2) == 0) && (k >= 2) && (k <= 16)) begin
        exp_data = 32'hA500_0080 + 32'((k - 2) / 2);
        checks++; if (cpu_rdata !== exp_data) begin errors++; $display("FAIL b2b_cpudata_c%0d: got %h want %h", k, cpu_rdata, exp_data); end
      end
    end
  endtask

  initial begin
    resetn    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    cpu_wmask = 4'b0000;
    cpu_rstrb = 1'b0;
    m1_req    = 1'b0;
    m1_we     = 1'b0;
    m1_lock   = 1'b0;
    m1_addr   = 32'h0;
    m1_wdata  = 32'h0;
    m1_wmask  = 4'b0000;
    for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 | 32'(i);
    ram[4] = 32'hDEAD_BEEF;

    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_contention();
    test_lock();
    test_reset_inflight();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
Two-master arbiter that shares the single Memory (RAM) port between the FemtoRV32 CPU and a second bus master, the screen framebuffer fetch engine. It sits between the CPU's RAM-qualified strobes and the Memory instance in SOC. It captures CPU requests, applies round-robin arbitration with a bounded M1 lock, and drives the CPU's mem_rbusy/mem_wbusy.

Parameters:
LOCK_MAX, 8, maximum consecutive M1 grants while m1_lock=1 before the CPU is given one slot (range 1..255).
CPU_FIRST, 1, which master wins the first contention after reset (1 = CPU).

Ports:
clk  in  1  system clock
resetn  in  1  reset, synchronous, active-low
cpu_addr  in  32  CPU address, sampled on strobe
cpu_wdata  in  32  CPU write data
cpu_wmask  in  4  CPU byte write mask; nonzero = write strobe (one cycle)
cpu_rstrb  in  1  CPU read strobe (one cycle)
cpu_rdata  out  32  read data to CPU; valid in the cycle cpu_rbusy falls
cpu_rbusy  out  1  CPU read outstanding
cpu_wbusy  out  1  CPU write outstanding
m1_req  in  1  M1 request; held with all m1_* inputs until m1_gnt
m1_we  in  1  1 = write, 0 = read
m1_lock  in  1  request back-to-back grants
m1_addr  in  32  M1 address
m1_wdata  in  32  M1 write data
m1_wmask  in  4  M1 byte mask (writes)
m1_gnt  out  1  one-cycle pulse: M1 access issued this cycle
m1_rvalid  out  1  one-cycle pulse: m1_rdata valid (cycle after read grant)
m1_rdata  out  32  read data to M1
s_addr  out  32  to Memory mem_addr
s_wdata  out  32  to Memory mem_wdata
s_wmask  out  4  to Memory mem_wmask
s_rstrb  out  1  to Memory mem_rstrb
s_rdata  in  32  from Memory; valid the cycle after s_rstrb

Behaviour:
- Reset (resetn=0 at a clk edge): CPU pending register cleared, in-flight tag cleared, lock counter=0, RR pointer set to CPU_FIRST. cpu_rbusy, cpu_wbusy, m1_gnt, m1_rvalid, s_rstrb=0, s_wmask=0. Any in-flight read is dropped; no rvalid is produced.
- CPU capture: in cycle T with cpu_rstrb or |cpu_wmask, latch addr/wdata/wmask/type into pend. Write wins if both are asserted. A strobe while pend is full is ignored (protocol violation; bench asserts).
- Issue: the slave accepts one access per cycle. Candidates in each cycle are pend (CPU) and m1_req. The winner drives s_*; the loser waits. Earliest CPU issue is T+1.
- Arbitration: only one requester present -> that requester wins. On contention, the master not granted last wins (RR pointer updates on every grant).
- Lock override: if M1 won last and m1_lock=1 and lock_cnt<LOCK_MAX, M1 wins again and lock_cnt increments. When lock_cnt reaches LOCK_MAX, the CPU wins the next contention. lock_cnt clears on any CPU grant or when m1_lock=0.
- CPU read timing, uncontended: strobe T, s_rstrb T+1, cpu_rbusy=1 in T+1, cpu_rbusy=0 with cpu_rdata=s_rdata in T+2. Each lost arbitration adds one cycle of cpu_rbusy.
- CPU write timing: s_wmask=pend mask in the issue cycle. cpu_wbusy=1 from T+1 through the issue cycle, 0 after.
- M1: m1_gnt=1 in the issue cycle, when s_* reflects m1_* combinationally. For a read, m1_rvalid=1 in the next cycle with m1_rdata=s_rdata. M1 may present a new request in the cycle after m1_gnt.
- An in-flight tag (1 bit plus valid) routes s_rdata to the correct master. Back-to-back reads from alternating masters must not mis-route.
- Idle: s_wmask=0, s_rstrb=0. s_addr holds its last value (don't care).

Decomposition:
- Package ram_arb_pkg: MASTER_CPU=1'b0, MASTER_M1=1'b1, request-type encodings (REQ_RD, REQ_WR), LOCK_CNT_W=8.
- One sub-module, rr_pick2: two-requester round-robin picker with lock override. Inputs: req[1:0], last, lock_ok. Output: grant one-hot.

Test Plan:
- Uncontended CPU read of 0x0000_0010 (RAM holds 0xDEADBEEF): strobe T -> s_rstrb T+1, cpu_rbusy 1 at T+1 only, cpu_rdata=0xDEADBEEF at T+2.
- CPU write 0x0000_0020, wmask=4'b0011, wdata=0x1234ABCD -> s_wmask=4'b0011 at T+1, cpu_wbusy high T+1 only; readback returns low half 0xABCD.
- CPU read and M1 read both pending, RR last=CPU -> M1 granted T+1 (m1_rvalid T+2), CPU issued T+2, cpu_rbusy falls T+3; data routed correctly.
- M1 lock with m1_lock=1, LOCK_MAX=4, CPU read pending -> exactly 4 consecutive m1_gnt, CPU granted on the 5th slot, then M1 resumes.
- resetn=0 in the cycle after a CPU read issue -> next cycle cpu_rbusy=0, m1_rvalid=0, no stale data delivered; first request after reset is served normally.
- Alternating M1/CPU reads every cycle for 16 cycles with distinct data -> every response reaches its own master, with zero mis-routes.
